// File: rtl/float_stream_sorter.sv
// -----------------------------------------------------------------------------
// float_stream_sorter
//
// Collects a batch of N floating-point words from an input stream, sorts them
// into increasing order with a bubble-sort engine that time-shares a single
// f_less_or_equal comparator, and streams them out with a last marker.
//
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   up_valid     - input element valid
//   up_ready     - block accepts input (high only while loading)
//   up_data      - input FP element (FLEN bits)
//   down_valid   - sorted output element valid (high only while draining)
//   down_ready   - downstream accepts output element
//   down_data    - sorted FP element, zero outside the drain phase
//   down_last    - marks the N-th (largest) element of a batch
//   down_err     - comparator reported a NaN somewhere in this batch
//   dbg_state    - current FSM state (0 load, 1 sort, 2 drain)
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high; valid never depends on ready, and down_* never depend on up_* or
// down_ready combinationally. up_ready depends on the FSM state only.
// -----------------------------------------------------------------------------

// IEEE-754 "a <= b" with -0 == +0. Any NaN operand raises err and forces
// res low; the sorter ignores res whenever err is set.
module f_less_or_equal #(
    parameter int FLEN = 64
) (
    input  logic [FLEN-1:0] a,
    input  logic [FLEN-1:0] b,
    output logic            res,
    output logic            err
);
    localparam int EXP_W = (FLEN == 64) ? 11 : (FLEN == 32) ? 8 : 5;
    localparam int MAN_W = FLEN - 1 - EXP_W;

    logic            a_sign, b_sign, a_nan, b_nan;
    logic [FLEN-2:0] a_mag, b_mag;

    assign a_sign = a[FLEN-1];
    assign b_sign = b[FLEN-1];
    assign a_mag  = a[FLEN-2:0];
    assign b_mag  = b[FLEN-2:0];
    assign a_nan  = (&a[FLEN-2 -: EXP_W]) && (|a[MAN_W-1:0]);
    assign b_nan  = (&b[FLEN-2 -: EXP_W]) && (|b[MAN_W-1:0]);

    always_comb begin
        err = a_nan || b_nan;
        res = 1'b0;
        if (err) begin
            res = 1'b0;
        end else if (a_mag == '0 && b_mag == '0) begin
            res = 1'b1;                 // signed zeros compare equal
        end else if (a_sign != b_sign) begin
            res = a_sign;               // negative is the smaller one
        end else if (!a_sign) begin
            res = (a_mag <= b_mag);
        end else begin
            res = (a_mag >= b_mag);     // larger magnitude is more negative
        end
    end
endmodule

module float_stream_sorter #(
    parameter int FLEN = 64,
    parameter int N    = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            up_valid,
    output logic            up_ready,
    input  logic [FLEN-1:0] up_data,
    output logic            down_valid,
    input  logic            down_ready,
    output logic [FLEN-1:0] down_data,
    output logic            down_last,
    output logic            down_err,
    output logic [1:0]      dbg_state
);
    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] CMP_LAST = IDX_W'(N - 2);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_SORT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_nx;
    logic [FLEN-1:0]   buf_q [N];
    logic [IDX_W-1:0]  idx_q, pass_q, idx_b;
    logic              err_r;
    logic [FLEN-1:0]   cmp_a, cmp_b;
    logic              cmp_res, cmp_err;
    logic              up_fire, down_fire;

    // Second comparator operand; the clamp only matters outside SORT, where
    // the comparator result is unused.
    assign idx_b = (idx_q == LAST_IDX) ? idx_q : idx_q + IDX_W'(1);
    assign cmp_a = buf_q[idx_q];
    assign cmp_b = buf_q[idx_b];

    f_less_or_equal #(.FLEN(FLEN)) u_cmp (
        .a   (cmp_a),
        .b   (cmp_b),
        .res (cmp_res),
        .err (cmp_err)
    );

    assign up_fire   = up_valid && up_ready;
    assign down_fire = down_valid && down_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_LOAD;
        else        state_q <= state_nx;
    end

    // Next-state logic; SORT always runs the full (N-1)^2 compare schedule
    always_comb begin
        state_nx = state_q;
        case (state_q)
            S_LOAD:  if (up_fire && idx_q == LAST_IDX) state_nx = S_SORT;
            S_SORT:  if (idx_q == CMP_LAST && pass_q == CMP_LAST) state_nx = S_DRAIN;
            S_DRAIN: if (down_fire && idx_q == LAST_IDX) state_nx = S_LOAD;
            default: state_nx = S_LOAD;
        endcase
    end

    // Outputs
    always_comb begin
        up_ready   = (state_q == S_LOAD);
        down_valid = (state_q == S_DRAIN);
        down_data  = '0;
        down_last  = 1'b0;
        down_err   = 1'b0;
        if (state_q == S_DRAIN) begin
            down_data = buf_q[idx_q];
            down_last = (idx_q == LAST_IDX);
            down_err  = err_r;
        end
    end

    assign dbg_state = state_q;

    // Datapath: buffer, element index, pass counter, sticky error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q  <= '0;
            pass_q <= '0;
            err_r  <= 1'b0;
            for (int i = 0; i < N; i++) buf_q[i] <= '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (up_fire) begin
                        buf_q[idx_q] <= up_data;
                        if (idx_q == LAST_IDX) begin
                            idx_q  <= '0;
                            pass_q <= '0;
                            err_r  <= 1'b0;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                S_SORT: begin
                    // Swap only on a clean "greater than"; equal pairs stay put
                    if (cmp_err) begin
                        err_r <= 1'b1;
                    end else if (!cmp_res) begin
                        buf_q[idx_q] <= cmp_b;
                        buf_q[idx_b] <= cmp_a;
                    end
                    if (idx_q == CMP_LAST) begin
                        idx_q  <= '0;
                        pass_q <= pass_q + IDX_W'(1);
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (down_fire) begin
                        if (idx_q == LAST_IDX) idx_q <= '0;
                        else                   idx_q <= idx_q + IDX_W'(1);
                    end
                end
                default: idx_q <= '0;
            endcase
        end
    end
endmodule
